// File: rtl/mmse_precal_seq_pkg.sv
// Shared types and helpers for the MMSE pre-calculation sequencer.
package mmse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Full-precision accumulator width: product (2W), sum of two products (+1),
  // then N accumulated terms (+clog2(N)).
  function automatic int acc_width(input int n, input int w);
    return 2 * w + 1 + $clog2(n);
  endfunction

endpackage

// File: rtl/mmse_precal_seq_if.sv
// Job/result handshake bundle between a producer and the sequencer.
interface mmse_precal_seq_if
  import mmse_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int ACC_W = acc_width(N, W)
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [W-1:0]     h_re [N][N];
  logic signed [W-1:0]     h_im [N][N];
  logic signed [W-1:0]     r_re [N];
  logic signed [W-1:0]     r_im [N];
  logic signed [W-1:0]     snr;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] a_re [N][N];
  logic signed [ACC_W-1:0] a_im [N][N];
  logic signed [ACC_W-1:0] b_re [N];
  logic signed [ACC_W-1:0] b_im [N];

  modport master (
    output in_valid, h_re, h_im, r_re, r_im, snr, out_ready,
    input  in_ready, out_valid, a_re, a_im, b_re, b_im
  );

  modport slave (
    input  in_valid, h_re, h_im, r_re, r_im, snr, out_ready,
    output in_ready, out_valid, a_re, a_im, b_re, b_im
  );

endinterface

// File: rtl/mmse_precal_seq_cmac.sv
// Conjugate complex MAC: acc += conj(x) * y, full precision.
// sum_* is the accumulator plus the current term, so the caller can store a
// finished element on the same edge that clears the accumulator.
module cmac_conj #(
  parameter int W     = 16,
  parameter int ACC_W = 2 * W + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [W-1:0]     x_re,
  input  logic signed [W-1:0]     x_im,
  input  logic signed [W-1:0]     y_re,
  input  logic signed [W-1:0]     y_im,
  output logic signed [ACC_W-1:0] acc_re,
  output logic signed [ACC_W-1:0] acc_im,
  output logic signed [ACC_W-1:0] sum_re,
  output logic signed [ACC_W-1:0] sum_im
);

  localparam int EXT = ACC_W - 2 * W;

  logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;

  assign p_rr = x_re * y_re;
  assign p_ii = x_im * y_im;
  assign p_ri = x_re * y_im;
  assign p_ir = x_im * y_re;

  assign sum_re = acc_re + {{EXT{p_rr[2*W-1]}}, p_rr} + {{EXT{p_ii[2*W-1]}}, p_ii};
  assign sum_im = acc_im + {{EXT{p_ri[2*W-1]}}, p_ri} - {{EXT{p_ir[2*W-1]}}, p_ir};

  // Accumulator: clear takes priority so a finished element restarts at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (clear) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (en) begin
      acc_re <= sum_re;
      acc_im <= sum_im;
    end
  end

endmodule

// File: rtl/mmse_precal_seq.sv
// MMSE pre-calculation: A = H^H*H + snr*I and b = H^H*r, one MAC term per cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a job; result registers hold the previous result
// CALC    | walking upper triangle of A (row-major), then b[0..N-1]
// DONE    | result valid and frozen until out_ready
module mmse_precal_seq
  import mmse_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int ACC_W = acc_width(N, W)
) (
  input  logic             clk,
  input  logic             reset,
  mmse_precal_seq_if.slave bus,
  output logic             busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  state_t              state;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                phase_b;
  logic [IW-1:0]       idx_i, idx_j, idx_k;

  logic signed [W-1:0] h_re_q [N][N];
  logic signed [W-1:0] h_im_q [N][N];
  logic signed [W-1:0] r_re_q [N];
  logic signed [W-1:0] r_im_q [N];
  logic signed [W-1:0] snr_q;

  logic signed [ACC_W-1:0] a_re_q [N][N];
  logic signed [ACC_W-1:0] a_im_q [N][N];
  logic signed [ACC_W-1:0] b_re_q [N];
  logic signed [ACC_W-1:0] b_im_q [N];

  logic signed [W-1:0]     x_re, x_im, y_re, y_im;
  logic signed [ACC_W-1:0] acc_re, acc_im, sum_re, sum_im, snr_ext;
  logic                    elem_last, mac_en, mac_clear, accept;

  assign accept    = (state == ST_IDLE) && bus.in_valid;
  assign elem_last = (idx_k == LAST);
  assign mac_en    = (state == ST_CALC);
  assign mac_clear = (state != ST_CALC) || elem_last;
  assign snr_ext   = {{(ACC_W - W){snr_q[W-1]}}, snr_q};

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.a_re      = a_re_q;
  assign bus.a_im      = a_im_q;
  assign bus.b_re      = b_re_q;
  assign bus.b_im      = b_im_q;

  // Operand select: x is always H[k][i]; y is H[k][j] for A, r[k] for b.
  always_comb begin
    x_re = h_re_q[idx_k][idx_i];
    x_im = h_im_q[idx_k][idx_i];
    y_re = h_re_q[idx_k][idx_j];
    y_im = h_im_q[idx_k][idx_j];
    if (phase_b) begin
      y_re = r_re_q[idx_k];
      y_im = r_im_q[idx_k];
    end
  end

  cmac_conj #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_cmac (
    .clk    (clk),
    .reset  (reset),
    .clear  (mac_clear),
    .en     (mac_en),
    .x_re   (x_re),
    .x_im   (x_im),
    .y_re   (y_re),
    .y_im   (y_im),
    .acc_re (acc_re),
    .acc_im (acc_im),
    .sum_re (sum_re),
    .sum_im (sum_im)
  );

  // Job capture: snapshot inputs on acceptance so later input changes are invisible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_re_q <= '{default: '0};
      h_im_q <= '{default: '0};
      r_re_q <= '{default: '0};
      r_im_q <= '{default: '0};
      snr_q  <= '0;
    end else if (accept) begin
      h_re_q <= bus.h_re;
      h_im_q <= bus.h_im;
      r_re_q <= bus.r_re;
      r_im_q <= bus.r_im;
      snr_q  <= bus.snr;
    end
  end

  // Sequencer FSM with element (i, j, phase) and term (k) counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b1;
      busy        <= 1'b0;
      out_valid_q <= 1'b0;
      phase_b     <= 1'b0;
      idx_i       <= '0;
      idx_j       <= '0;
      idx_k       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state      <= ST_CALC;
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
            phase_b    <= 1'b0;
            idx_i      <= '0;
            idx_j      <= '0;
            idx_k      <= '0;
          end
        end
        ST_CALC: begin
          if (!elem_last) begin
            idx_k <= idx_k + ONE;
          end else begin
            idx_k <= '0;
            if (!phase_b) begin
              if (idx_j != LAST) begin
                idx_j <= idx_j + ONE;
              end else if (idx_i != LAST) begin
                idx_i <= idx_i + ONE;
                idx_j <= idx_i + ONE;
              end else begin
                phase_b <= 1'b1;
                idx_i   <= '0;
                idx_j   <= '0;
              end
            end else if (idx_i != LAST) begin
              idx_i <= idx_i + ONE;
            end else begin
              state       <= ST_DONE;
              busy        <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          in_ready_q  <= 1'b1;
          busy        <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Result store: write each element on its final term; mirror A off-diagonals
  // as the conjugate and fold snr into the diagonal.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_re_q <= '{default: '0};
      a_im_q <= '{default: '0};
      b_re_q <= '{default: '0};
      b_im_q <= '{default: '0};
    end else if ((state == ST_CALC) && elem_last) begin
      if (phase_b) begin
        b_re_q[idx_i] <= sum_re;
        b_im_q[idx_i] <= sum_im;
      end else if (idx_i == idx_j) begin
        a_re_q[idx_i][idx_i] <= sum_re + snr_ext;
        a_im_q[idx_i][idx_i] <= '0;
      end else begin
        a_re_q[idx_i][idx_j] <= sum_re;
        a_im_q[idx_i][idx_j] <= sum_im;
        a_re_q[idx_j][idx_i] <= sum_re;
        a_im_q[idx_j][idx_i] <= -sum_im;
      end
    end
  end

endmodule

// File: tb/tb_mmse_precal_seq.sv
// Scoreboard bench for mmse_precal_seq: driver pushes model results, monitor checks.
module tb_mmse_precal_seq;

  localparam int N     = 4;
  localparam int W     = 16;
  localparam int ACC_W = 2 * W + 1 + $clog2(N);
  localparam int LAT   = N * (N * (N + 1) / 2 + N);

  typedef struct {
    int hr [N][N];
    int hi [N][N];
    int rr [N];
    int ri [N];
    int snr;
  } job_t;

  typedef struct {
    longint are [N][N];
    longint aim [N][N];
    longint bre [N];
    longint bim [N];
    int     acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [$];

  mmse_precal_seq_if #(.N(N), .W(W), .ACC_W(ACC_W)) bus ();

  mmse_precal_seq #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Golden model straight from the matrix definitions, full matrix computed.
  function automatic exp_t model(input job_t jb);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint re = 0, im = 0;
        for (int k = 0; k < N; k++) begin
          re += longint'(jb.hr[k][i]) * jb.hr[k][j] + longint'(jb.hi[k][i]) * jb.hi[k][j];
          im += longint'(jb.hr[k][i]) * jb.hi[k][j] - longint'(jb.hi[k][i]) * jb.hr[k][j];
        end
        if (i == j) re += jb.snr;
        e.are[i][j] = re;
        e.aim[i][j] = im;
      end
      e.bre[i] = 0;
      e.bim[i] = 0;
      for (int k = 0; k < N; k++) begin
        e.bre[i] += longint'(jb.hr[k][i]) * jb.rr[k] + longint'(jb.hi[k][i]) * jb.ri[k];
        e.bim[i] += longint'(jb.hr[k][i]) * jb.ri[k] - longint'(jb.hi[k][i]) * jb.rr[k];
      end
    end
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic cmp_out(input exp_t e);
    string  what = "";
    longint act = 0, req = 0;
    for (int i = N - 1; i >= 0; i--) begin
      for (int j = N - 1; j >= 0; j--) begin
        if (longint'(bus.a_re[i][j]) != e.are[i][j]) begin
          what = $sformatf("a_re[%0d][%0d]", i, j); act = bus.a_re[i][j]; req = e.are[i][j];
        end
        if (longint'(bus.a_im[i][j]) != e.aim[i][j]) begin
          what = $sformatf("a_im[%0d][%0d]", i, j); act = bus.a_im[i][j]; req = e.aim[i][j];
        end
      end
      if (longint'(bus.b_re[i]) != e.bre[i]) begin
        what = $sformatf("b_re[%0d]", i); act = bus.b_re[i]; req = e.bre[i];
      end
      if (longint'(bus.b_im[i]) != e.bim[i]) begin
        what = $sformatf("b_im[%0d]", i); act = bus.b_im[i]; req = e.bim[i];
      end
    end
    checks++;
    if (what != "") begin
      errors++;
      $display("FAIL result %s actual=%0d required=%0d (cycle %0d)", what, act, req, cyc);
    end
  endtask

  // Monitor: one-hot status every cycle; result compared on every DONE cycle.
  initial begin : monitor
    bit prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      chk("status_onehot", int'(bus.in_ready) + int'(busy) + int'(bus.out_valid), 1);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          if (!prev_ov) chk("latency", cyc - exp_q[0].acc_cyc, LAT);
          cmp_out(exp_q[0]);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = bus.out_valid && !bus.out_ready;
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int rs16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic job_t rand_job();
    job_t jb;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        jb.hr[k][i] = rs16();
        jb.hi[k][i] = rs16();
      end
      jb.rr[k] = rs16();
      jb.ri[k] = rs16();
    end
    jb.snr = rs16();
    return jb;
  endfunction

  task automatic drive_job(input job_t jb);
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        bus.h_re[k][i] = W'(jb.hr[k][i]);
        bus.h_im[k][i] = W'(jb.hi[k][i]);
      end
      bus.r_re[k] = W'(jb.rr[k]);
      bus.r_im[k] = W'(jb.ri[k]);
    end
    bus.snr = W'(jb.snr);
  endtask

  // Called just after a rising edge; returns just after the edge following acceptance.
  task automatic issue_job(input job_t jb);
    exp_t e;
    bit   ok = 1'b0;
    drive_job(jb);
    bus.in_valid = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e = model(jb);
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus.out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("out_valid_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic finish_job(input int delay);
    wait_valid();
    repeat (delay) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    longint nz = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) nz |= bus.a_re[i][j] | bus.a_im[i][j];
      nz |= bus.b_re[i] | bus.b_im[i];
    end
    chk(name, nz, 0);
  endtask

  initial begin : stimulus
    job_t jb, jb2;
    int   hs;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    jb = '{default: 0};
    drive_job(jb);
    reset = 1'b0;

    // Reset state, clocked while held.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk_all_zero("rst_outputs_zero");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // out_ready while idle has no effect.
    bus.out_ready = 1'b1;
    repeat (3) begin @(negedge clk); chk("idle_ready_noeffect", bus.in_ready, 1); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Identity H, r = 1..4, snr = 5.
    jb = '{default: 0};
    for (int k = 0; k < N; k++) begin jb.hr[k][k] = 1; jb.rr[k] = k + 1; end
    jb.snr = 5;
    issue_job(jb);
    finish_job(0);
    chk("ident_a_diag", bus.a_re[2][2], 6);
    chk("ident_a_off", bus.a_re[0][3], 0);
    chk("ident_b_re3", bus.b_re[3], 4);
    chk("ident_b_im1", bus.b_im[1], 0);

    // Most negative real H, snr = 0: every a_re is 2^32.
    jb = '{default: 0};
    for (int k = 0; k < N; k++) for (int i = 0; i < N; i++) jb.hr[k][i] = -32768;
    issue_job(jb);
    finish_job(1);
    chk("neg_a_re12", bus.a_re[1][2], 64'sh1_0000_0000);
    chk("neg_a_re33", bus.a_re[3][3], 64'sh1_0000_0000);
    chk("neg_a_im21", bus.a_im[2][1], 0);

    // Hold in DONE for 10 cycles with in_valid pulses carrying other data.
    jb  = rand_job();
    jb2 = rand_job();
    issue_job(jb);
    wait_valid();
    for (int c = 0; c < 10; c++) begin
      drive_job(jb2);
      bus.in_valid = c[0];
      @(negedge clk);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_out_valid", bus.out_valid, 1);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_no_extra_job", busy, 0);

    // Reset 20 cycles into CALC aborts the job.
    issue_job(rand_job());
    repeat (19) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_busy", busy, 0);
    chk_all_zero("abort_outputs_zero");
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    issue_job(rand_job());
    finish_job(0);

    // in_valid held high across the DONE handshake.
    issue_job(rand_job());
    wait_valid();
    bus.out_ready = 1'b1;
    hs = cyc + 1;
    issue_job(rand_job());
    bus.out_ready = 1'b0;
    chk("b2b_accept_cycle", exp_q[$].acc_cyc, hs + 1);
    finish_job(2);

    // Randomized jobs.
    for (int n = 0; n < 200; n++) begin
      issue_job(rand_job());
      finish_job(int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmse_precal_seq.md
MMSE_PRECAL_SEQ -- requirements
Module: mmse_precal_seq

Interface
REQ-001 Parameter N, default 4: antenna/stream count; square matrix dimension; legal 2..8.
REQ-002 Parameter W, default 16: signed two's-complement width of each real/imag input component.
REQ-003 Parameter ACC_W, default 2*W+1+$clog2(N): signed output component width; SHALL NOT be overridden.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  job request; H, r and snr valid.
REQ-007 in_ready  output  1  block can accept a job.
REQ-008 h_re, h_im  input  [N][N] x W  channel matrix H, row k = receive antenna, column i = stream.
REQ-009 r_re, r_im  input  [N] x W  received vector r.
REQ-010 snr  input  W  signed regularisation term, sign-extended before use.
REQ-011 out_valid  output  1  A and b complete and stable.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 a_re, a_im  output  [N][N] x ACC_W  A = H^H*H + snr*I.
REQ-014 b_re, b_im  output  [N] x ACC_W  b = H^H*r.
REQ-015 busy  output  1  high in CALC.

Function
REQ-016 FSM states are IDLE, CALC and DONE; reset state is IDLE.
REQ-017 in_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in CALC; out_valid SHALL be 1 only in DONE.
REQ-018 IDLE with in_valid=1: H, r and snr SHALL be captured into internal registers; next state is CALC.
REQ-019 Inputs SHALL be ignored when in_ready=0; later changes to inputs SHALL NOT affect the running job.
REQ-020 CALC SHALL use one complex conjugate MAC, executing one term per cycle, in this order: the upper triangle of A in row-major order (i<=j), then b[0..N-1]; each element takes N cycles, k=0..N-1.
REQ-021 Each term is conj(x)*y: re = xr*yr + xi*yi, im = xr*yi - xi*yr; all arithmetic is full-precision signed, with no saturation and no rounding.
REQ-022 A[i][j] = sum_k conj(H[k][i])*H[k][j]; b[i] = sum_k conj(H[k][i])*r[k].
REQ-023 On completion of A[i][j] with i<j, a[j][i] SHALL be written as the conjugate (re equal, im negated) in the same cycle.
REQ-024 Diagonal elements: a_im[i][i] SHALL be forced to 0, and a_re[i][i] SHALL be the MAC result plus the sign-extended snr.
REQ-025 Latency from the accepting edge to out_valid=1 SHALL be exactly N*(N*(N+1)/2+N) cycles (56 for N=4).
REQ-026 In DONE, out_valid SHALL hold and the outputs SHALL stay stable until out_ready=1; the handshake edge returns the FSM to IDLE.
REQ-027 The result registers SHALL update only as elements complete; outside CALC they hold their last values.
REQ-028 out_ready=1 when out_valid=0 SHALL have no effect.
REQ-029 A new job SHALL NOT be accepted in the same cycle as the DONE handshake; the earliest acceptance is the following cycle.

Reset
REQ-030 While reset=0, state SHALL be IDLE, in_ready SHALL be 1 (busy=0, out_valid=0), and all a_*, b_* and internal accumulators SHALL be 0, regardless of clock.
REQ-031 Reset asserted during CALC or DONE SHALL abort the job with no partial result retained.

Structure
REQ-032 Package mmse_pkg SHALL hold the FSM state enum and an acc_width(N, W) function.
REQ-033 Sub-module cmac_conj SHALL hold the conjugate complex multiply-accumulate, with ports for clear, enable, x, y and acc_re/acc_im.
REQ-034 Element and k indices SHALL be counters, not unrolled logic; exactly one multiplier set (4 W x W) is permitted.

Verification
REQ-035 N=4, W=16: H=I (real), r=(1,2,3,4), snr=5 -> a_re diag=6, all other a=0, b_re=(1,2,3,4), b_im=0, out_valid at cycle 56.
REQ-036 All h_re=-32768, h_im=0, snr=0 -> every a_re=2^32, a_im=0; no overflow at ACC_W=35.
REQ-037 Random complex H/r/snr, 200 jobs vs golden model -> exact match; a[j][i]=conj(a[i][j]); a_im diag=0.
REQ-038 out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0; in_valid pulses are ignored.
REQ-039 reset=0 at CALC cycle 20 -> outputs 0, state IDLE, in_ready=1; the next job completes correctly.
REQ-040 in_valid held high across the DONE handshake -> next job is accepted exactly 1 cycle after the handshake.
